line_mem_responder: RTL and testbench
=====================================

LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 Parameter LATENCY, default 4: clock edges from request acceptance to resp_valid assertion; legal range 1..15.
REQ-002 Parameter LINE_ADDR_BITS, default 8: number of line-index bits; storage is 2**LINE_ADDR_BITS lines of 256 bits.
REQ-003 Port CLK  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 Port RST_N  input  1  asynchronous, active-low reset.
REQ-005 Port req_valid  input  1  the cache presents a line request.
REQ-006 Port req_ready  output  1  the responder can accept a request.
REQ-007 Port req_write  input  1  1 = line writeback, 0 = line fill (read).
REQ-008 Port req_addr  input  32  byte address; bits [4:0] ignored; line index = req_addr[LINE_ADDR_BITS+4:5]; upper bits ignored, so addresses alias by wrap-around.
REQ-009 Port req_wdata  input  256  writeback line; word i = bits [32*i+31:32*i].
REQ-010 Port req_wmask  input  8  per-word write enable for writebacks; ignored on reads.
REQ-011 Port resp_valid  output  1  the response is available.
REQ-012 Port resp_ready  input  1  the cache accepts the response.
REQ-013 Port resp_rdata  output  256  fill data; all zeros for write responses.
REQ-014 Port resp_write  output  1  the response acknowledges a writeback.
REQ-015 Port busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM has three states: IDLE, WAIT and RESP.
REQ-017 IDLE: req_ready=1 and resp_valid=0.
REQ-018 IDLE: on req_valid&&req_ready at an edge, the block captures req_write, the line index, req_wdata and req_wmask, loads the latency counter with LATENCY-1 and enters WAIT.
REQ-019 Inputs are sampled only at the accepting edge; changes to the request inputs afterwards have no effect on the transaction.
REQ-020 WAIT: req_ready=0; the counter decrements by 1 each edge while nonzero.
REQ-021 WAIT: at the edge where the counter is 0, the block performs the access and enters RESP; resp_valid therefore first goes high exactly LATENCY edges after the accepting edge.
REQ-022 Write access: only the words with req_wmask[i]=1 are updated; unmasked words retain their contents.
REQ-023 Read access: resp_rdata is loaded with the full stored line.
REQ-024 RESP: resp_valid=1, and resp_rdata and resp_write are held stable until the handshake.
REQ-025 RESP: at an edge with resp_ready=1 the block returns to IDLE, and resp_valid, resp_write and resp_rdata return to 0.
REQ-026 resp_ready is ignored outside RESP.
REQ-027 req_ready is 0 in RESP, so a new request cannot be accepted in the same edge as a response handshake; the earliest next acceptance is the following edge, from IDLE.
REQ-028 A read that follows a write to the same line returns the post-write contents.
REQ-029 A read of a never-written line returns unspecified data and is not checked.
REQ-030 Each transaction occupies at least LATENCY+2 edges from acceptance to the next acceptance.

Reset
REQ-031 When RST_N=0, the block immediately enters IDLE.
REQ-032 During reset: resp_valid=0, resp_write=0, resp_rdata=0, busy=0, counter=0 and captured request registers=0.
REQ-033 req_ready reads 1 after RST_N deasserts.
REQ-034 Storage contents are not cleared by reset.
REQ-035 If reset asserts while in WAIT before the access edge, the pending write is discarded and storage is unchanged.
REQ-036 If reset asserts while in RESP, the response is dropped.

Verification
REQ-037 Write then read: write addr 0x40, mask 0xFF, data {8 words 0x11111111..0x88888888}, LATENCY=4 -> resp_valid rises 4 edges after acceptance with resp_write=1; a read of 0x40 returns the identical line with resp_write=0.
REQ-038 Partial write: write 0x40 with mask 0x05 and all words 0xDEADBEEF -> a later read returns words 0 and 2 = 0xDEADBEEF, and words 1 and 3..7 unchanged from REQ-037.
REQ-039 Backpressure: hold resp_ready=0 for 6 cycles in RESP while req_valid=1 -> resp_valid stays 1, data is stable, req_ready=0 and no second acceptance occurs until the edge after the handshake.
REQ-040 Alias and offset: write line at 0x0000_0020, then read 0x0000_203F (LINE_ADDR_BITS=8) -> same line data returned.
REQ-041 Reset mid-WAIT: accept a write to 0x80, assert RST_N=0 two edges later -> outputs go to reset values immediately, and a later read of 0x80 returns the pre-write contents.
REQ-042 LATENCY=1 build: a read is accepted at edge N -> resp_valid=1 after edge N+1.

Source files
------------

// File: rtl/line_mem_responder_if.sv
// Line request/response channel between a cache (master) and a line memory (slave).
// Latency: none, wires only.
// Backpressure: req_valid/req_ready on requests, resp_valid/resp_ready on responses.
interface line_mem_responder_if;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [31:0]  req_addr;
    logic [255:0] req_wdata;
    logic [7:0]   req_wmask;
    logic         resp_valid;
    logic         resp_ready;
    logic [255:0] resp_rdata;
    logic         resp_write;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_write
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_write
    );
endinterface

// File: rtl/line_mem_responder.sv
// Fixed-latency 256-bit line memory answering cache fills and masked writebacks.
// Latency: resp_valid rises LATENCY edges after the accepting edge.
// Backpressure: one transaction in flight; req_ready low until the response handshakes.
module line_mem_responder #(
    parameter int LATENCY        = 4,
    parameter int LINE_ADDR_BITS = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    line_mem_responder_if.slave  bus,
    output logic                 busy
);
    localparam int LINES = 1 << LINE_ADDR_BITS;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [255:0]              mem [LINES];
    state_t                    state;
    logic [3:0]                cnt;
    logic                      cap_write;
    logic [LINE_ADDR_BITS-1:0] cap_idx;
    logic [255:0]              cap_wdata;
    logic [7:0]                cap_wmask;
    logic                      access;

    // Byte offset and bits above the line index alias away on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req_addr[31:LINE_ADDR_BITS+5], bus.req_addr[4:0]};

    // The access edge is the last WAIT edge; reset forces IDLE so a pending write is dropped.
    assign access = (state == WAIT) && (cnt == 4'd0);

    // Control FSM with all handshake outputs and the captured request registered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            cap_write      <= 1'b0;
            cap_idx        <= '0;
            cap_wdata      <= '0;
            cap_wmask      <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_write <= 1'b0;
            bus.resp_rdata <= '0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        cap_write     <= bus.req_write;
                        cap_idx       <= bus.req_addr[LINE_ADDR_BITS+4:5];
                        cap_wdata     <= bus.req_wdata;
                        cap_wmask     <= bus.req_wmask;
                        cnt           <= 4'(LATENCY - 1);
                        bus.req_ready <= 1'b0;
                        busy          <= 1'b1;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_write <= cap_write;
                        bus.resp_rdata <= cap_write ? '0 : mem[cap_idx];
                        state          <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.resp_write <= 1'b0;
                        bus.resp_rdata <= '0;
                        bus.req_ready  <= 1'b1;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                    bus.resp_write <= 1'b0;
                    bus.resp_rdata <= '0;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

    // Storage survives reset; writebacks update only the enabled 32-bit words.
    always_ff @(posedge CLK) begin
        if (access && cap_write) begin
            for (int i = 0; i < 8; i++) begin
                if (cap_wmask[i]) begin
                    mem[cap_idx][32*i +: 32] <= cap_wdata[32*i +: 32];
                end
            end
        end
    end
endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: vector table plus backpressure, reset and LATENCY=1 sequences.
// Latency: checks resp_valid timing against LATENCY edge counts.
// Backpressure: exercises held resp_ready=0 with a pending request.
module tb_line_mem_responder;
    logic CLK;
    logic RST_N;
    logic busy0;
    logic busy1;
    int   compared;
    int   mismatched;

    line_mem_responder_if bus0 ();
    line_mem_responder_if bus1 ();

    line_mem_responder #(.LATENCY(4), .LINE_ADDR_BITS(8)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .bus(bus0), .busy(busy0)
    );
    line_mem_responder #(.LATENCY(1), .LINE_ADDR_BITS(8)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .bus(bus1), .busy(busy1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [7:0]   wmask;
        logic [255:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] fill(input logic [31:0] w);
        return {8{w}};
    endfunction

    function automatic logic [255:0] merge(input logic [255:0] old_line, input logic [255:0] new_line,
                                           input logic [7:0] mask);
        logic [255:0] r;
        r = old_line;
        for (int i = 0; i < 8; i++) if (mask[i]) r[32*i +: 32] = new_line[32*i +: 32];
        return r;
    endfunction

    // Full transaction on dut0: accept, scramble inputs, time the response, handshake, check idle.
    task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [255:0] wdata, input logic [7:0] wmask,
                           output logic [255:0] rdata, output logic rwrite, output int lat);
        int t;
        @(negedge CLK);
        bus0.req_valid  = 1'b1;
        bus0.req_write  = wr;
        bus0.req_addr   = addr;
        bus0.req_wdata  = wdata;
        bus0.req_wmask  = wmask;
        bus0.resp_ready = 1'b0;
        t = 0;
        while (!bus0.req_ready && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 50) chk({tag, " req_ready timeout"}, 256'(bus0.req_ready), 256'd1);
        @(posedge CLK);
        @(negedge CLK);
        bus0.req_valid = 1'b0;
        bus0.req_write = ~wr;
        bus0.req_addr  = ~addr;
        bus0.req_wdata = ~wdata;
        bus0.req_wmask = ~wmask;
        chk({tag, " busy in WAIT"}, 256'(busy0), 256'd1);
        chk({tag, " req_ready in WAIT"}, 256'(bus0.req_ready), 256'd0);
        lat = 0;
        do begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
        end while (!bus0.resp_valid && lat < 40);
        rdata  = bus0.resp_rdata;
        rwrite = bus0.resp_write;
        bus0.resp_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus0.resp_ready = 1'b0;
        chk({tag, " resp_valid after hs"}, 256'(bus0.resp_valid), 256'd0);
        chk({tag, " resp_rdata after hs"}, bus0.resp_rdata, 256'd0);
        chk({tag, " resp_write after hs"}, 256'(bus0.resp_write), 256'd0);
        chk({tag, " req_ready after hs"}, 256'(bus0.req_ready), 256'd1);
    endtask

    initial begin
        logic [255:0] w1, w2, w3, w4, w5, rd;
        logic         rw;
        int           lat;
        int           t;

        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 8; i++) begin
            w1[32*i +: 32] = 32'h11111111 * (i + 1);
            w3[32*i +: 32] = 32'h30303030 ^ i;
            w4[32*i +: 32] = 32'h40400000 + i;
        end
        w2 = merge(w1, fill(32'hDEADBEEF), 8'h05);
        w5 = merge(w4, fill(32'hCAFEF00D), 8'h80);

        vecs[0] = '{1'b1, 32'h0000_0040, w1,                8'hFF, 256'd0};
        vecs[1] = '{1'b0, 32'h0000_0040, fill(32'hFFFFFFFF), 8'hFF, w1};
        vecs[2] = '{1'b1, 32'h0000_0040, fill(32'hDEADBEEF), 8'h05, 256'd0};
        vecs[3] = '{1'b0, 32'h0000_0040, fill(32'h0),        8'h00, w2};
        vecs[4] = '{1'b1, 32'h0000_0020, w3,                8'hFF, 256'd0};
        vecs[5] = '{1'b0, 32'h0000_203F, fill(32'hFFFFFFFF), 8'hFF, w3};
        vecs[6] = '{1'b1, 32'h0000_0080, w4,                8'hFF, 256'd0};
        vecs[7] = '{1'b0, 32'h0000_0080, fill(32'h0),        8'h00, w4};
        vecs[8] = '{1'b1, 32'h0000_0080, fill(32'hCAFEF00D), 8'h80, 256'd0};
        vecs[9] = '{1'b0, 32'h0000_0080, fill(32'h0),        8'h00, w5};

        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0;
        bus0.req_wdata = '0;   bus0.req_wmask = '0;   bus0.resp_ready = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0;
        bus1.req_wdata = '0;   bus1.req_wmask = '0;   bus1.resp_ready = 1'b0;
        RST_N = 1'b1;
        #2 RST_N = 1'b0;

        // Reset state.
        @(negedge CLK);
        chk("rst resp_valid", 256'(bus0.resp_valid), 256'd0);
        chk("rst resp_write", 256'(bus0.resp_write), 256'd0);
        chk("rst resp_rdata", bus0.resp_rdata, 256'd0);
        chk("rst busy", 256'(busy0), 256'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("post-rst req_ready", 256'(bus0.req_ready), 256'd1);

        // Vector table.
        for (int v = 0; v < 10; v++) begin
            run_txn($sformatf("vec%0d", v), vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].wmask, rd, rw, lat);
            chk($sformatf("vec%0d latency", v), 256'(lat), 256'd4);
            chk($sformatf("vec%0d resp_write", v), 256'(rw), 256'(vecs[v].wr));
            chk($sformatf("vec%0d resp_rdata", v), rd, vecs[v].exp_rdata);
        end

        // Backpressure: resp_ready low for 6 cycles with a second request pending.
        @(negedge CLK);
        bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_addr = 32'h40; bus0.resp_ready = 1'b0;
        @(posedge CLK);
        t = 0;
        do begin
            @(negedge CLK);
            if (!bus0.resp_valid) @(posedge CLK);
            t++;
        end while (!bus0.resp_valid && t < 40);
        chk("bp resp_valid timeout", 256'(bus0.resp_valid), 256'd1);
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("bp%0d resp_valid", c), 256'(bus0.resp_valid), 256'd1);
            chk($sformatf("bp%0d resp_rdata", c), bus0.resp_rdata, w2);
            chk($sformatf("bp%0d req_ready", c), 256'(bus0.req_ready), 256'd0);
            @(posedge CLK);
            @(negedge CLK);
        end
        bus0.resp_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus0.resp_ready = 1'b0;
        chk("bp hs-edge no accept busy", 256'(busy0), 256'd0);
        chk("bp hs-edge req_ready", 256'(bus0.req_ready), 256'd1);
        @(posedge CLK);
        @(negedge CLK);
        bus0.req_valid = 1'b0;
        chk("bp second accept busy", 256'(busy0), 256'd1);
        t = 0;
        while (!bus0.resp_valid && t < 40) begin
            @(negedge CLK);
            t++;
        end
        chk("bp second resp_rdata", bus0.resp_rdata, w2);
        bus0.resp_ready = 1'b1;
        @(negedge CLK);
        bus0.resp_ready = 1'b0;

        // Reset two edges into a write's WAIT: write dropped, outputs reset at once.
        @(negedge CLK);
        bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_addr = 32'h80;
        bus0.req_wdata = fill(32'h55555555); bus0.req_wmask = 8'hFF;
        @(posedge CLK);
        @(negedge CLK);
        bus0.req_valid = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("midwait rst busy", 256'(busy0), 256'd0);
        chk("midwait rst resp_valid", 256'(bus0.resp_valid), 256'd0);
        chk("midwait rst req_ready", 256'(bus0.req_ready), 256'd1);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        run_txn("after midwait rst", 1'b0, 32'h80, fill(32'h0), 8'h00, rd, rw, lat);
        chk("after midwait rst rdata", rd, w5);
        chk("after midwait rst latency", 256'(lat), 256'd4);

        // LATENCY=1 instance: response visible right after the edge following acceptance.
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            bus1.req_valid = 1'b1; bus1.req_write = (k == 0); bus1.req_addr = 32'h40;
            bus1.req_wdata = w1; bus1.req_wmask = 8'hFF; bus1.resp_ready = 1'b0;
            @(posedge CLK);
            @(negedge CLK);
            bus1.req_valid = 1'b0;
            chk($sformatf("lat1 t%0d resp_valid after N", k), 256'(bus1.resp_valid), 256'd0);
            chk($sformatf("lat1 t%0d busy after N", k), 256'(busy1), 256'd1);
            @(posedge CLK);
            @(negedge CLK);
            chk($sformatf("lat1 t%0d resp_valid after N+1", k), 256'(bus1.resp_valid), 256'd1);
            chk($sformatf("lat1 t%0d resp_write", k), 256'(bus1.resp_write), 256'(k == 0));
            chk($sformatf("lat1 t%0d resp_rdata", k), bus1.resp_rdata, (k == 0) ? 256'd0 : w1);
            bus1.resp_ready = 1'b1;
            @(negedge CLK);
            bus1.resp_ready = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
